// File: rtl/cp_remover.sv
// Receive-side cyclic-prefix remover: tracks OFDM symbol boundaries in a serial
// CP+symbol stream and forwards exactly NFFT useful samples per symbol with framing flags.
module cp_remover #(
    parameter int WIDTH         = 26,
    parameter int NFFT          = 2048,
    parameter int CP_LONG       = 160,
    parameter int CP_SHORT      = 144,
    parameter int SYMS_PER_HALF = 7,
    parameter int WIN_BACKOFF   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sync,
    input  logic signed [WIDTH-1:0] in_r,
    input  logic signed [WIDTH-1:0] in_i,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_r,
    output logic signed [WIDTH-1:0] out_i,
    output logic                    out_first,
    output logic                    out_last,
    output logic [2:0]              sym_idx,
    output logic                    locked,
    output logic                    resync_err
);
    localparam int CW = $clog2(CP_LONG + NFFT);
    localparam logic [2:0] LAST_SYM = 3'(SYMS_PER_HALF - 1);

    typedef enum logic [1:0] {IDLE, CP_DROP, DATA, TAIL} state_t;

    state_t        state, state_nxt, eff_state;
    logic [CW-1:0] samp_cnt, samp_nxt, cur_samp;
    logic [CW-1:0] win_start, win_end, sym_end;
    logic [2:0]    sym_cnt, sym_nxt, cur_sym;
    logic          restart, resync, fwd;

    // An accepted in_sync overrides the counters: the sample is treated as CP sample 0
    // of symbol 0, whatever the FSM was doing.
    always_comb begin
        restart   = in_valid && in_sync;
        resync    = restart && (state != IDLE) && !(samp_cnt == '0 && sym_cnt == '0);
        eff_state = restart ? CP_DROP : state;
        cur_samp  = restart ? '0 : samp_cnt;
        cur_sym   = restart ? '0 : sym_cnt;
        win_start = (cur_sym == '0) ? CW'(CP_LONG - WIN_BACKOFF) : CW'(CP_SHORT - WIN_BACKOFF);
        win_end   = win_start + CW'(NFFT - 1);
        sym_end   = (cur_sym == '0) ? CW'(CP_LONG + NFFT - 1) : CW'(CP_SHORT + NFFT - 1);
    end

    always_comb begin
        state_nxt = state;
        samp_nxt  = samp_cnt;
        sym_nxt   = sym_cnt;
        fwd       = 1'b0;
        if (in_valid && eff_state != IDLE) begin
            state_nxt = eff_state;
            samp_nxt  = cur_samp + CW'(1);
            sym_nxt   = cur_sym;
            case (eff_state)
                CP_DROP: if (cur_samp == win_start - CW'(1)) state_nxt = DATA;
                DATA: begin
                    fwd = 1'b1;
                    if (cur_samp == win_end)
                        state_nxt = (WIN_BACKOFF == 0) ? CP_DROP : TAIL;
                end
                TAIL: if (cur_samp == sym_end) state_nxt = CP_DROP;
                default: state_nxt = IDLE;
            endcase
            if (cur_samp == sym_end) begin
                samp_nxt = '0;
                sym_nxt  = (cur_sym == LAST_SYM) ? 3'd0 : cur_sym + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            sym_cnt    <= '0;
            out_valid  <= 1'b0;
            out_r      <= '0;
            out_i      <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            sym_idx    <= '0;
            locked     <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            samp_cnt   <= samp_nxt;
            sym_cnt    <= sym_nxt;
            out_valid  <= fwd;
            out_first  <= fwd && (cur_samp == win_start);
            out_last   <= fwd && (cur_samp == win_end);
            resync_err <= resync;
            if (restart) locked <= 1'b1;
            // Data and symbol index hold between forwarded samples.
            if (fwd) begin
                out_r <= in_r;
                out_i <= in_i;
            end
            if (fwd && cur_samp == win_start) sym_idx <= cur_sym;
        end
    end
endmodule

// File: tb/tb_cp_remover.sv
// Bench for cp_remover: two instances (backoff 0 and 16) share one stimulus stream and are
// checked every cycle against a position-arithmetic reference model with expected queues.
module tb_cp_remover;
    localparam int W    = 26;
    localparam int NFFT = 2048;
    localparam int CPL  = 160;
    localparam int CPS  = 144;
    localparam int SPH  = 7;
    localparam int BO_A = 0;
    localparam int BO_B = 16;
    localparam int EW   = 5 + 2 * W;
    localparam int HW   = 3 + 2 * W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_sync = 1'b0;
    logic signed [W-1:0] in_r = '0;
    logic signed [W-1:0] in_i = '0;

    logic                ov[2], of_[2], ol[2], lk[2], re[2];
    logic signed [W-1:0] orr[2], oi[2];
    logic [2:0]          si[2];

    int n_checks = 0;
    int n_errors = 0;

    int             m_samp[2], m_sym[2];
    bit             m_lock[2], exp_valid[2], exp_err[2];
    logic [HW-1:0]  hold[2];
    logic [EW-1:0]  exp_q_a[$];
    logic [EW-1:0]  exp_q_b[$];

    cp_remover #(.WIDTH(W), .NFFT(NFFT), .CP_LONG(CPL), .CP_SHORT(CPS),
                 .SYMS_PER_HALF(SPH), .WIN_BACKOFF(BO_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
        .in_r(in_r), .in_i(in_i), .out_valid(ov[0]), .out_r(orr[0]), .out_i(oi[0]),
        .out_first(of_[0]), .out_last(ol[0]), .sym_idx(si[0]), .locked(lk[0]),
        .resync_err(re[0])
    );

    cp_remover #(.WIDTH(W), .NFFT(NFFT), .CP_LONG(CPL), .CP_SHORT(CPS),
                 .SYMS_PER_HALF(SPH), .WIN_BACKOFF(BO_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
        .in_r(in_r), .in_i(in_i), .out_valid(ov[1]), .out_r(orr[1]), .out_i(oi[1]),
        .out_first(of_[1]), .out_last(ol[1]), .sym_idx(si[1]), .locked(lk[1]),
        .resync_err(re[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_samp[d] = 0; m_sym[d] = 0; m_lock[d] = 0;
            exp_valid[d] = 0; exp_err[d] = 0; hold[d] = '0;
        end
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    // Reference: absolute position within the symbol decides whether a sample is useful.
    task automatic model_step(input int d, input bit v, input bit sy,
                              input logic [W-1:0] r, input logic [W-1:0] i);
        int bo, cp, start;
        logic [EW-1:0] w;
        bo = (d == 0) ? BO_A : BO_B;
        exp_valid[d] = 0;
        exp_err[d]   = 0;
        if (!v) return;
        if (sy) begin
            if (m_lock[d] && (m_samp[d] != 0 || m_sym[d] != 0)) exp_err[d] = 1;
            m_lock[d] = 1; m_samp[d] = 0; m_sym[d] = 0;
        end
        if (!m_lock[d]) return;
        cp    = (m_sym[d] == 0) ? CPL : CPS;
        start = cp - bo;
        if (m_samp[d] >= start && m_samp[d] < start + NFFT) begin
            exp_valid[d] = 1;
            w = {m_samp[d] == start, m_samp[d] == start + NFFT - 1, 3'(m_sym[d]), r, i};
            if (d == 0) exp_q_a.push_back(w);
            else        exp_q_b.push_back(w);
        end
        m_samp[d]++;
        if (m_samp[d] == cp + NFFT) begin
            m_samp[d] = 0;
            m_sym[d]  = (m_sym[d] + 1) % SPH;
        end
    endtask

    task automatic check_cycle(input int d);
        logic [EW-1:0] obs, w_exp;
        string sfx;
        sfx = (d == 0) ? "_bo0" : "_bo16";
        obs = {of_[d], ol[d], si[d], orr[d], oi[d]};
        check({"out_valid", sfx}, 64'(ov[d]), 64'(exp_valid[d]));
        check({"locked", sfx}, 64'(lk[d]), 64'(m_lock[d]));
        check({"resync_err", sfx}, 64'(re[d]), 64'(exp_err[d]));
        if (ov[d]) begin
            w_exp = 'x;
            if (d == 0 && exp_q_a.size() > 0) w_exp = exp_q_a.pop_front();
            if (d == 1 && exp_q_b.size() > 0) w_exp = exp_q_b.pop_front();
            check({"out_word", sfx}, 64'(obs), 64'(w_exp));
            hold[d] = w_exp[HW-1:0];
        end else begin
            check({"idle_hold", sfx}, 64'(obs), 64'({2'b00, hold[d]}));
        end
    endtask

    task automatic drive(input bit v, input bit sy, input logic [W-1:0] r);
        logic [W-1:0] i;
        i = W'($urandom);
        in_valid = v; in_sync = sy; in_r = r; in_i = i;
        model_step(0, v, sy, r, i);
        model_step(1, v, sy, r, i);
        @(posedge clk);
        #1;
        check_cycle(0);
        check_cycle(1);
    endtask

    // One symbol's samples n_from..n_to, valued by position; optional ~30% random gaps.
    task automatic drive_sym(input int sym, input int n_from, input int n_to,
                             input bit gaps, input bit sync0);
        for (int n = n_from; n <= n_to; n++) begin
            if (gaps)
                while ($urandom_range(0, 99) < 30) drive(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
            drive(1'b1, sync0 && n == 0 && sym == 0, W'(n));
        end
    endtask

    function automatic int sym_len(input int sym);
        return ((sym == 0) ? CPL : CPS) + NFFT;
    endfunction

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_cycle(0);
        check_cycle(1);
        @(negedge clk);
        rst = 1'b1;

        // Idle input before lock produces nothing
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, W'(k));

        // Gapless half-subframe: one long and six short symbols
        for (int s = 0; s < SPH; s++) drive_sym(s, 0, sym_len(s) - 1, 1'b0, 1'b1);

        // Expected-boundary sync, then a gapped half-subframe with sync toggling on gaps
        for (int s = 0; s < SPH; s++) drive_sym(s, 0, sym_len(s) - 1, 1'b1, 1'b1);

        // Resync at sample 1000 of symbol 3 truncates that symbol
        for (int s = 0; s < 3; s++) drive_sym(s, 0, sym_len(s) - 1, 1'b0, 1'b1);
        drive_sym(3, 0, 999, 1'b0, 1'b0);
        drive_sym(0, 0, sym_len(0) - 1, 1'b0, 1'b1);
        drive_sym(1, 0, 700, 1'b1, 1'b0);

        // Asynchronous reset in the middle of DATA
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_cycle(0);
        check_cycle(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Unsynced input after reset stays silent, then relock
        for (int k = 0; k < 3000; k++) drive(1'b1, 1'b0, W'(k));
        drive_sym(0, 0, sym_len(0) - 1, 1'b0, 1'b1);
        drive_sym(1, 0, 200, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0);

        check("leftover_bo0", 64'(exp_q_a.size()), 64'd0);
        check("leftover_bo16", 64'(exp_q_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cp_remover.md
Name: cp_remover

Overview:
- Receive-side counterpart of the transmit CP-insertion/IFFT buffer for the 5G NR chain, 2048-point numerology.
- Accepts a continuous serial time-domain stream (CP + symbol), tracks symbol boundaries and discards each symbol's cyclic prefix.
- Emits exactly NFFT samples per OFDM symbol, with framing flags, to the downstream FFT.
- Supports a configurable FFT-window backoff into the CP for timing-error margin.

Parameters:
- WIDTH, 26, bit width of each I and Q sample (signed).
- NFFT, 2048, useful samples per symbol.
- CP_LONG, 160, CP length of symbol 0 of each half-subframe.
- CP_SHORT, 144, CP length of symbols 1..SYMS_PER_HALF-1.
- SYMS_PER_HALF, 7, symbols per half-subframe.
- WIN_BACKOFF, 0, samples by which the output window starts before the end of the CP. Legal range 0..CP_SHORT-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input sample qualifier. No backpressure.
- in_sync  input  1  marks the first CP sample of symbol 0 of a half-subframe. Valid only with in_valid.
- in_r  input  WIDTH  signed real input sample.
- in_i  input  WIDTH  signed imaginary input sample.
- out_valid  output  1  output sample qualifier.
- out_r  output  WIDTH  signed real output sample.
- out_i  output  WIDTH  signed imaginary output sample.
- out_first  output  1  high with out_valid on the first useful sample of a symbol.
- out_last  output  1  high with out_valid on useful sample NFFT-1.
- sym_idx  output  3  symbol index 0..SYMS_PER_HALF-1 of the current output, held between symbols.
- locked  output  1  high after the first in_sync is accepted.
- resync_err  output  1  one-cycle pulse when in_sync arrives while not at a symbol boundary.

Behaviour:
- Reset (async, rst=0): all outputs 0. FSM=IDLE. samp_cnt=0. sym_cnt=0.
- Only cycles with in_valid=1 advance state. When in_valid=0, all counters and the FSM hold and out_valid=0. Gaps of any length are allowed mid-symbol.
- Symbol length: L = cp + NFFT, where cp = CP_LONG if sym_cnt==0, else CP_SHORT.
  - Long symbol: L = 2208, samp_cnt 0..2207.
  - Short symbol: L = 2192, samp_cnt 0..2191.
- Output window: useful samples have samp_cnt in [cp-WIN_BACKOFF, cp-WIN_BACKOFF+NFFT-1]. The trailing WIN_BACKOFF samples of each symbol are dropped.
- FSM states:
  - IDLE: discard input; wait for in_valid&in_sync.
  - CP_DROP: discard samples while samp_cnt < cp-WIN_BACKOFF.
  - DATA: forward NFFT samples.
  - TAIL: discard WIN_BACKOFF samples. Skipped when WIN_BACKOFF=0.
- Transitions:
  - IDLE -> CP_DROP on in_valid&in_sync. That sample is samp_cnt=0, sym_cnt=0, and locked is set.
  - CP_DROP -> DATA when the sample at samp_cnt = cp-WIN_BACKOFF-1 is accepted.
  - DATA -> TAIL (or directly to CP_DROP of the next symbol) on the accepted NFFT-th data sample.
- End of symbol (sample samp_cnt=L-1 accepted):
  - samp_cnt <= 0.
  - sym_cnt <= sym_cnt+1, wrapping from SYMS_PER_HALF-1 to 0.
- Latency: exactly 1 clock. A sample accepted at edge k appears on out_r/out_i with out_valid at edge k+1.
- Data path: out_r/out_i are registered copies of the inputs, unmodified. They hold their last value when out_valid=0.
- sym_idx updates together with out_first.
- in_sync at the expected boundary (the accepted sample would be samp_cnt=0, sym_cnt=0): accepted silently, no error.
- in_sync anywhere else after lock:
  - resync_err pulses 1 cycle.
  - Counters restart: that sample becomes samp_cnt=0, sym_cnt=0.
  - A partially output symbol is truncated: no out_last is issued for it.
- in_sync while in_valid=0: ignored.
- Without in_sync, the block free-runs on its counters indefinitely.
- Reset mid-symbol: outputs clear immediately, locked=0, and the block waits in IDLE.

Test Plan:
- Reset, then in_sync plus 2208 contiguous samples with value n (n=0..2207) -> 2048 outputs of values 160..2207. out_first on value 160, out_last on value 2207, sym_idx=0, each 1 cycle after its input.
- Continue with 6 short symbols and a new in_sync -> each symbol outputs its own samples 144..2191 with sym_idx 1..6. The next in_sync produces no resync_err, and sym_idx returns to 0.
- Random in_valid gaps (~30%) over a full half-subframe -> the output sequence is identical to the gapless run, and out_valid is never high on a gap cycle.
- in_sync injected at samp_cnt=1000 of symbol 3 -> resync_err pulses once, no out_last for symbol 3, and the next outputs start at the new symbol 0 offset 160.
- WIN_BACKOFF=16 -> a long symbol outputs input indices 144..2191 and a short symbol outputs 128..2175, still 2048 samples each.
- rst asserted mid-DATA -> out_valid and locked drop immediately, and there is no output until the next in_sync.
